// File: rtl/fetch_stream_unit.sv
// Fetch front end: one bus request per line, buffered line drained into decode in groups,
// with branch-prediction handoff, fence.i serialisation and flush/redirect recovery.
module fetch_stream_unit #(
   parameter int                    FETCH_WIDTH = 4,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INST_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] INIT_PC     = ADDR_WIDTH'(32'h8000_0000)
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic [ADDR_WIDTH-1:0]             bus_req_addr,
   output logic                              bus_req_valid,
   input  logic                              bus_req_ready,
   input  logic [FETCH_WIDTH*INST_WIDTH-1:0] bus_rsp_data,
   input  logic                              bus_rsp_valid,
   output logic [ADDR_WIDTH-1:0]             bp_pc,
   output logic [INST_WIDTH-1:0]             bp_inst,
   output logic                              bp_req,
   input  logic                              bp_rsp_valid,
   input  logic                              bp_jump,
   input  logic [ADDR_WIDTH-1:0]             bp_next_pc,
   input  logic [$clog2(FETCH_WIDTH):0]      dec_free,
   output logic [FETCH_WIDTH-1:0]            dec_valid,
   output logic [FETCH_WIDTH*INST_WIDTH-1:0] dec_inst,
   output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] dec_pc,
   output logic [FETCH_WIDTH-1:0]            dec_exc,
   output logic [FETCH_WIDTH-1:0]            dec_predicted,
   output logic                              dec_pred_jump,
   output logic [ADDR_WIDTH-1:0]             dec_pred_next_pc,
   input  logic                              pipe_idle,
   input  logic                              flush,
   input  logic [ADDR_WIDTH-1:0]             flush_pc,
   input  logic                              redirect,
   input  logic [ADDR_WIDTH-1:0]             redirect_pc,
   output logic                              stat_bus_stall,
   output logic                              stat_dec_stall
);

   localparam int HW = $clog2(FETCH_WIDTH);
   localparam int CW = HW + 1;
   localparam logic [ADDR_WIDTH-1:0] INST_BYTES = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(4 * FETCH_WIDTH);

   typedef enum logic [2:0] {S_REQ, S_WAIT, S_DRAIN, S_JWAIT, S_FWAIT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [HW-1:0]         head_q, head_d;
   logic                  discard_q, discard_d;
   logic [INST_WIDTH-1:0] line_buf [FETCH_WIDTH];
   logic                  load;

   // Lanes viewed relative to head: rel_*[0] is the oldest unconsumed instruction.
   logic [CW-1:0]         abs_idx  [FETCH_WIDTH];
   logic [INST_WIDTH-1:0] rel_inst [FETCH_WIDTH];
   logic [ADDR_WIDTH-1:0] rel_pc   [FETCH_WIDTH];
   logic [FETCH_WIDTH-1:0] rel_exc, rel_ctrl, rel_fence;

   logic [CW-1:0]         remaining, n_max, grp_n, emit_n, head_sum;
   logic                  end_ctrl, end_exc, stop;
   logic [HW-1:0]         end_slot;
   logic                  fence_head, fence_go, all_done;
   logic [ADDR_WIDTH-1:0] end_pc, pred_next;
   logic                  drain_st, emit_ok, pred_taken, req_fire;

   always_comb begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         abs_idx[k]   = {1'b0, head_q} + CW'(k);
         rel_inst[k]  = line_buf[abs_idx[k][HW-1:0]];
         rel_pc[k]    = base_q + (ADDR_WIDTH'(abs_idx[k]) << 2);
         rel_exc[k]   = rel_pc[k][1:0] != 2'b00;
         rel_ctrl[k]  = rel_inst[k][6:0] == 7'h6F || rel_inst[k][6:0] == 7'h67 ||
                        rel_inst[k][6:0] == 7'h63 ||
                        rel_inst[k] == INST_WIDTH'(32'h3020_0073);
         rel_fence[k] = rel_inst[k][6:0] == 7'h0F && rel_inst[k][14:12] == 3'b001;
      end
   end

   // Group formation: up to n_max lanes, cut after an exception or control
   // instruction, and cut before a fence.i so it always travels alone.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      remaining = CW'(FETCH_WIDTH) - {1'b0, head_q};
      n_max     = (dec_free < remaining) ? dec_free : remaining;
      grp_n     = '0;
      end_ctrl  = 1'b0;
      end_exc   = 1'b0;
      end_slot  = '0;
      stop      = 1'b0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (!stop && CW'(k) < n_max) begin
            if (rel_exc[k]) begin
               grp_n    = CW'(k + 1);
               end_exc  = 1'b1;
               end_slot = HW'(k);
               stop     = 1'b1;
            end else if (rel_fence[k]) begin
               stop = 1'b1;
            end else if (rel_ctrl[k]) begin
               grp_n    = CW'(k + 1);
               end_ctrl = 1'b1;
               end_slot = HW'(k);
               stop     = 1'b1;
            end else begin
               grp_n = CW'(k + 1);
            end
         end
      end
      fence_head = rel_fence[0] && !rel_exc[0];
      fence_go   = fence_head && pipe_idle && (dec_free != '0);
      emit_n     = fence_go ? CW'(1) : grp_n;
      head_sum   = {1'b0, head_q} + grp_n;
      all_done   = head_sum == CW'(FETCH_WIDTH);
      end_pc     = rel_pc[end_slot];
      pred_next  = bp_jump ? bp_next_pc : end_pc + INST_BYTES;
   end

   assign drain_st   = state_q == S_DRAIN || state_q == S_FWAIT;
   assign emit_ok    = rst && !flush && drain_st;
   assign pred_taken = end_ctrl && bp_rsp_valid;
   assign req_fire   = bus_req_valid && bus_req_ready;
   assign load       = !flush && state_q == S_WAIT && bus_rsp_valid;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (!rst) begin
         state_q   <= S_REQ;
         pc_q      <= INIT_PC;
         base_q    <= '0;
         head_q    <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         base_q    <= base_d;
         head_q    <= head_d;
         discard_q <= discard_d;
      end
   end

   // NOTE: the line buffer has no reset; it is only read in DRAIN/FWAIT, after a load.
   always_ff @(posedge clk) begin
      if (load) begin
         for (int k = 0; k < FETCH_WIDTH; k++)
            line_buf[k] <= bus_rsp_data[k*INST_WIDTH +: INST_WIDTH];
      end
   end

   // Next-state
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      base_d    = base_q;
      head_d    = head_q;
      discard_d = discard_q;
      if (discard_q && bus_rsp_valid)
         discard_d = 1'b0;
      if (flush) begin
         state_d = S_REQ;
         pc_d    = flush_pc;
         if ((state_q == S_WAIT && !bus_rsp_valid) || (state_q == S_REQ && req_fire))
            discard_d = 1'b1;
      end else begin
         unique case (state_q)
            S_REQ: if (req_fire) state_d = S_WAIT;
            S_WAIT: begin
               if (bus_rsp_valid) begin
                  head_d  = '0;
                  base_d  = pc_q;
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN, S_FWAIT: begin
               if (fence_head) begin
                  if (fence_go) begin
                     pc_d    = rel_pc[0] + INST_BYTES;
                     state_d = S_REQ;
                  end else if (!pipe_idle) begin
                     state_d = S_FWAIT;
                  end
               end else if (grp_n != '0) begin
                  if (end_exc) begin
                     pc_d    = end_pc + INST_BYTES;
                     state_d = S_REQ;
                  end else if (end_ctrl) begin
                     if (bp_rsp_valid) begin
                        pc_d    = pred_next;
                        state_d = S_REQ;
                     end else begin
                        state_d = S_JWAIT;
                     end
                  end else begin
                     head_d = head_sum[HW-1:0];
                     if (all_done) begin
                        pc_d    = base_q + LINE_BYTES;
                        state_d = S_REQ;
                     end
                  end
               end
            end
            S_JWAIT: begin
               if (redirect) begin
                  pc_d    = redirect_pc;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      bus_req_valid    = rst && state_q == S_REQ && !discard_q;
      bus_req_addr     = rst ? pc_q : INIT_PC;
      stat_bus_stall   = rst && (state_q == S_REQ || state_q == S_WAIT);
      stat_dec_stall   = rst && state_q == S_DRAIN && dec_free == '0;
      bp_req           = emit_ok && end_ctrl;
      bp_pc            = bp_req ? end_pc : '0;
      bp_inst          = bp_req ? rel_inst[end_slot] : '0;
      dec_pred_jump    = emit_ok && pred_taken && bp_jump;
      dec_pred_next_pc = (emit_ok && pred_taken) ? pred_next : '0;
      dec_valid        = '0;
      dec_inst         = '0;
      dec_pc           = '0;
      dec_exc          = '0;
      dec_predicted    = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (emit_ok && CW'(k) < emit_n) begin
            dec_valid[k]                          = 1'b1;
            dec_inst[k*INST_WIDTH +: INST_WIDTH] = rel_exc[k] ? '0 : rel_inst[k];
            dec_pc[k*ADDR_WIDTH +: ADDR_WIDTH]   = rel_pc[k];
            dec_exc[k]                            = rel_exc[k];
            dec_predicted[k]                      = pred_taken && end_slot == HW'(k);
         end
      end
   end

endmodule
